// File: rtl/comma_aligner_rx.sv
// Serial 8b/10b receiver: K28.5 word alignment, sub-block decode, comma stripping.
// Outputs update on the edge that samples a group's 10th bit; no backpressure, a full FIFO drops the byte and sets overflow.
module comma_aligner_rx #(
  parameter int ALIGN_COMMAS = 2,
  parameter int ERR_THRESH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serial_in,
  input  logic       fifo_full,
  output logic       fifo_wen,
  output logic [7:0] dout,
  output logic       locked,
  output logic       code_err,
  output logic       overflow
);

  localparam int CW = $clog2(ALIGN_COMMAS + 1);
  localparam int EW = $clog2(ERR_THRESH + 1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t          state;
  // Only bits [9:1] of the previous window survive the next shift, so bit 0 is never stored.
  logic [8:0]      sr;
  logic [3:0]      bit_cnt;
  logic [CW-1:0]   comma_cnt;
  logic [EW-1:0]   err_cnt;

  logic [9:0] win_next;
  logic [5:0] abcdei;
  logic [3:0] fghj;
  logic [4:0] d5;
  logic [2:0] d3;
  logic       v6, v4, kx7, is_comma, valid_d, boundary;
  logic [7:0] dec_byte;

  assign win_next = {serial_in, sr};
  assign abcdei   = {win_next[0], win_next[1], win_next[2], win_next[3], win_next[4], win_next[5]};
  assign fghj     = {win_next[6], win_next[7], win_next[8], win_next[9]};
  assign is_comma = (win_next == 10'b0101111100) || (win_next == 10'b1010000011);
  assign boundary = (bit_cnt == 4'd9);
  assign dec_byte = {d3, d5};

  always_comb begin
    d5 = '0;
    v6 = 1'b1;
    case (abcdei)
      6'b100111, 6'b011000: d5 = 5'd0;
      6'b011101, 6'b100010: d5 = 5'd1;
      6'b101101, 6'b010010: d5 = 5'd2;
      6'b110001:            d5 = 5'd3;
      6'b110101, 6'b001010: d5 = 5'd4;
      6'b101001:            d5 = 5'd5;
      6'b011001:            d5 = 5'd6;
      6'b111000, 6'b000111: d5 = 5'd7;
      6'b111001, 6'b000110: d5 = 5'd8;
      6'b100101:            d5 = 5'd9;
      6'b010101:            d5 = 5'd10;
      6'b110100:            d5 = 5'd11;
      6'b001101:            d5 = 5'd12;
      6'b101100:            d5 = 5'd13;
      6'b011100:            d5 = 5'd14;
      6'b010111, 6'b101000: d5 = 5'd15;
      6'b011011, 6'b100100: d5 = 5'd16;
      6'b100011:            d5 = 5'd17;
      6'b010011:            d5 = 5'd18;
      6'b110010:            d5 = 5'd19;
      6'b001011:            d5 = 5'd20;
      6'b101010:            d5 = 5'd21;
      6'b011010:            d5 = 5'd22;
      6'b111010, 6'b000101: d5 = 5'd23;
      6'b110011, 6'b001100: d5 = 5'd24;
      6'b100110:            d5 = 5'd25;
      6'b010110:            d5 = 5'd26;
      6'b110110, 6'b001001: d5 = 5'd27;
      6'b001110:            d5 = 5'd28;
      6'b101110, 6'b010001: d5 = 5'd29;
      6'b011110, 6'b100001: d5 = 5'd30;
      6'b101011, 6'b010100: d5 = 5'd31;
      default:              v6 = 1'b0;
    endcase
  end

  always_comb begin
    d3 = '0;
    v4 = 1'b1;
    case (fghj)
      4'b1011, 4'b0100:                   d3 = 3'd0;
      4'b1001:                            d3 = 3'd1;
      4'b0101:                            d3 = 3'd2;
      4'b1100, 4'b0011:                   d3 = 3'd3;
      4'b1101, 4'b0010:                   d3 = 3'd4;
      4'b1010:                            d3 = 3'd5;
      4'b0110:                            d3 = 3'd6;
      4'b1110, 4'b0001, 4'b0111, 4'b1000: d3 = 3'd7;
      default:                            v4 = 1'b0;
    endcase
  end

  // K23/27/29/30.7 reuse data 6b codes; the 4b half is the A7 form of the "wrong" disparity.
  assign kx7 = (fghj == 4'b1000 && (abcdei == 6'b111010 || abcdei == 6'b110110 ||
                                    abcdei == 6'b101110 || abcdei == 6'b011110)) ||
               (fghj == 4'b0111 && (abcdei == 6'b000101 || abcdei == 6'b001001 ||
                                    abcdei == 6'b010001 || abcdei == 6'b100001));
  assign valid_d = v6 && v4 && !kx7;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      sr        <= '0;
      bit_cnt   <= '0;
      comma_cnt <= '0;
      err_cnt   <= '0;
      fifo_wen  <= 1'b0;
      dout      <= '0;
      locked    <= 1'b0;
      code_err  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      sr       <= win_next[9:1];
      fifo_wen <= 1'b0;
      code_err <= 1'b0;
      bit_cnt  <= boundary ? 4'd0 : bit_cnt + 4'd1;
      case (state)
        HUNT: if (is_comma) begin
          bit_cnt   <= '0;
          comma_cnt <= CW'(1);
          err_cnt   <= '0;
          if (ALIGN_COMMAS == 1) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end else begin
            state <= VERIFY;
          end
        end
        VERIFY: if (boundary) begin
          if (is_comma) begin
            comma_cnt <= comma_cnt + CW'(1);
            if (comma_cnt == CW'(ALIGN_COMMAS - 1)) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end else if (!valid_d) begin
            state     <= HUNT;
            comma_cnt <= '0;
          end
        end
        LOCKED: if (boundary) begin
          if (is_comma) begin
            err_cnt <= '0;
          end else if (valid_d) begin
            err_cnt <= '0;
            if (fifo_full) begin
              overflow <= 1'b1;
            end else begin
              dout     <= dec_byte;
              fifo_wen <= 1'b1;
            end
          end else begin
            code_err <= 1'b1;
            if (err_cnt == EW'(ERR_THRESH - 1)) begin
              state     <= HUNT;
              locked    <= 1'b0;
              err_cnt   <= '0;
              comma_cnt <= '0;
            end else begin
              err_cnt <= err_cnt + EW'(1);
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule
